// File: rtl/expression_pipe_pkg.sv
// Shared opcode enum and per-lane result type for the expression pipeline.
package expression_pipe_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_XNOR = 3'd2,
      OP_SHL  = 3'd3,
      OP_SHR  = 3'd4,
      OP_LT   = 3'd5,
      OP_RED  = 3'd6,
      OP_SEL  = 3'd7
   } op_e;

   localparam int unsigned LANES_DEF = 6;
   localparam int unsigned W_DEF     = 6;

endpackage

// Lane result record {res, ovf}; the width follows the lane width of the user.
`ifndef EXPRESSION_PIPE_LANE_RES_T
`define EXPRESSION_PIPE_LANE_RES_T(WIDTH) struct packed { logic [(WIDTH)-1:0] res; logic ovf; }
`endif

// File: rtl/expression_lane.sv
// One combinational lane: evaluates the selected expression on a/b with
// optional signedness and flags ADD/SUB overflow.
module expression_lane
   import expression_pipe_pkg::*;
#(
   parameter int W   = 6,
   parameter int SHW = $clog2(W) + 1
) (
   input  logic [2:0]   op,
   input  logic         sgn,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res,
   output logic         ovf_evt
);

   typedef `EXPRESSION_PIPE_LANE_RES_T(W) lane_res_t;

   logic [W:0]     ext_a;
   logic [W:0]     ext_b;
   logic [W:0]     sum;
   logic [W:0]     diff;
   logic [SHW-1:0] sh;
   logic [W+2:0]   red;
   lane_res_t      r;

   // Operands widened by one bit so carry/borrow and sign both stay visible.
   assign ext_a = sgn ? {a[W-1], a} : {1'b0, a};
   assign ext_b = sgn ? {b[W-1], b} : {1'b0, b};
   assign sum   = ext_a + ext_b;
   assign diff  = ext_a - ext_b;
   assign sh    = b[SHW-1:0];
   assign red   = {{W{1'b0}}, ^a, |b, &a};

   // Opcode decode into the lane result record.
   // NOTE: every field gets a default before the case so no latch is inferred.
   always_comb begin
      r = '0;
      case (op_e'(op))
         OP_ADD: begin
            r.res = sum[W-1:0];
            r.ovf = sgn ? (sum[W] ^ sum[W-1]) : sum[W];
         end
         OP_SUB: begin
            r.res = diff[W-1:0];
            r.ovf = sgn ? (diff[W] ^ diff[W-1]) : diff[W];
         end
         OP_XNOR: r.res = a ^ ~b;
         OP_SHL:  r.res = (int'(sh) >= W) ? '0 : (a << sh);
         OP_SHR: begin
            // Kept as separate branches: a ?: mixing signed and unsigned would
            // turn the arithmetic shift into a logical one.
            if (sgn) begin
               if (int'(sh) >= W) r.res = {W{a[W-1]}};
               else               r.res = $signed(a) >>> sh;
            end else begin
               if (int'(sh) >= W) r.res = '0;
               else               r.res = a >> sh;
            end
         end
         OP_LT:   r.res = {{(W-1){1'b0}}, ($signed(ext_a) < $signed(ext_b))};
         OP_RED:  r.res = red[W-1:0];
         OP_SEL:  r.res = (a != '0) ? b : ~b;
         default: r = '0;
      endcase
   end

   assign res     = r.res;
   assign ovf_evt = r.ovf;

endmodule

// File: rtl/expression_pipe.sv
// Two-stage valid/ready pipeline around LANES expression lanes, with sticky
// per-lane overflow flags and a synchronous flag clear.
module expression_pipe
   import expression_pipe_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = W_DEF,
   parameter int SHW   = $clog2(W) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [LANES-1:0]   sgn,
   input  logic [LANES*W-1:0] a,
   input  logic [LANES*W-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] y,
   output logic [LANES-1:0]   ovf,
   input  logic               ovf_clr
);

   logic               s1_valid_q, s1_valid_d;
   logic [2:0]         s1_op_q,    s1_op_d;
   logic [LANES-1:0]   s1_sgn_q,   s1_sgn_d;
   logic [LANES*W-1:0] s1_a_q,     s1_a_d;
   logic [LANES*W-1:0] s1_b_q,     s1_b_d;
   logic               s2_valid_q, s2_valid_d;
   logic [LANES*W-1:0] y_q,        y_d;
   logic [LANES-1:0]   s2_ovf_q,   s2_ovf_d;
   logic [LANES-1:0]   ovf_q,      ovf_d;

   logic [LANES*W-1:0] lane_y;
   logic [LANES-1:0]   lane_ovf;
   logic               s2_load;
   logic               s1_load;
   logic               out_fire;

   // Lanes evaluate the stage-1 operands; results land in stage 2.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      expression_lane #(.W(W), .SHW(SHW)) u_lane (
         .op      (s1_op_q),
         .sgn     (s1_sgn_q[i]),
         .a       (s1_a_q[i*W +: W]),
         .b       (s1_b_q[i*W +: W]),
         .res     (lane_y[i*W +: W]),
         .ovf_evt (lane_ovf[i])
      );
   end

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
   assign out_fire = s2_valid_q && out_ready;

   // Next-state for both stages and the sticky flags.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_sgn_d   = s1_sgn_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      s2_ovf_d   = s2_ovf_q;

      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_op_d  = op;
            s1_sgn_d = sgn;
            s1_a_d   = a;
            s1_b_d   = b;
         end
      end

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            y_d      = lane_y;
            s2_ovf_d = lane_ovf;
         end
      end

      // Clear first, then OR in the beat leaving this cycle so it is never lost.
      ovf_d = (ovf_clr ? '0 : ovf_q) | (out_fire ? s2_ovf_q : '0);
   end

   // State registers.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of the others.
   // NOTE: the operand/result registers are reset too, because y must read 0
   // out of reset; they are small, so there is no memory-reset penalty here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_sgn_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         s2_ovf_q   <= '0;
         ovf_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_sgn_q   <= s1_sgn_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         s2_ovf_q   <= s2_ovf_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign y         = y_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_expression_pipe.sv
// Directed bench for expression_pipe: opcode vectors, backpressure, flag
// clear priority and mid-stream reset.
module tb_expression_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [5:0]  sgn;
   logic [35:0] a;
   logic [35:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [35:0] y;
   logic [5:0]  ovf;
   logic        ovf_clr;

   int n_checks = 0;
   int n_pass   = 0;

   expression_pipe #(.LANES(6), .W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sgn       (sgn),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   function automatic logic [35:0] lv(input int lane, input logic [5:0] v);
      logic [35:0] t;
      t = {30'd0, v};
      return t << (lane * 6);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One beat through an empty pipe: accept, check latency, check result, drain.
   task automatic run_beat(input string tag, input logic [2:0] o, input logic [5:0] s,
                           input logic [35:0] av, input logic [35:0] bv,
                           input logic [35:0] y_exp, input logic clr);
      op = o; sgn = s; a = av; b = bv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1"}, out_valid, 0);
      tick();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_y"}, y, y_exp);
      ovf_clr = clr;
      tick();
      ovf_clr = 1'b0;
   endtask

   initial begin
      int idx;
      int n;
      int seen;
      logic acc;
      logic [5:0] got [5];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      op = 3'd0; sgn = '0; a = '0; b = '0;
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // ADD unsigned: 60+5 wraps to 1 with overflow; lane1 10+20=30.
      run_beat("add_u", 3'd0, 6'b000000, lv(0, 6'd60) | lv(1, 6'd10),
               lv(0, 6'd5) | lv(1, 6'd20), lv(0, 6'd1) | lv(1, 6'd30), 1'b0);
      check("add_u_ovf", ovf, 6'b000001);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check("clr_ovf", ovf, 0);

      // ADD signed: -4+5=1 no overflow; lane2 31+1 overflows to -32.
      run_beat("add_s", 3'd0, 6'b000101, lv(0, 6'b111100) | lv(2, 6'd31),
               lv(0, 6'd5) | lv(2, 6'd1), lv(0, 6'd1) | lv(2, 6'b100000), 1'b0);
      check("add_s_ovf", ovf, 6'b000100);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

      // SHR: signed/unsigned with amount >= W, then amount 2.
      run_beat("shr", 3'd4, 6'b001001,
               lv(0, 6'b100000) | lv(1, 6'b100000) | lv(2, 6'b100000) | lv(3, 6'b100000),
               lv(0, 6'd7) | lv(1, 6'd7) | lv(2, 6'd2) | lv(3, 6'd2),
               lv(0, 6'b111111) | lv(2, 6'b001000) | lv(3, 6'b111000), 1'b0);

      // SHL: 5<<3=40, 1<<6 saturates to 0, 1<<5=32.
      run_beat("shl", 3'd3, 6'b000000, lv(0, 6'd5) | lv(1, 6'd1) | lv(2, 6'd1),
               lv(0, 6'd3) | lv(1, 6'd6) | lv(2, 6'd5), lv(0, 6'd40) | lv(2, 6'd32), 1'b0);

      // LT: 63<1 unsigned false, -1<1 signed true.
      run_beat("lt", 3'd5, 6'b000010, lv(0, 6'b111111) | lv(1, 6'b111111),
               lv(0, 6'd1) | lv(1, 6'd1), lv(1, 6'd1), 1'b0);

      // RED {^a,|b,&a}: a=111111,b=0 -> 001; a=000001,b=000010 -> 110.
      run_beat("red", 3'd6, 6'b000000, lv(0, 6'b111111) | lv(1, 6'b000001),
               lv(1, 6'b000010), lv(0, 6'b000001) | lv(1, 6'b000110), 1'b0);

      // XNOR lane0; SEL covered next.
      run_beat("xnor", 3'd2, 6'b000000, lv(0, 6'b101010), lv(0, 6'b110011),
               lv(0, 6'b100110) | lv(1, 6'b111111) | lv(2, 6'b111111) |
               lv(3, 6'b111111) | lv(4, 6'b111111) | lv(5, 6'b111111), 1'b0);

      // SEL: a==0 -> ~b, a!=0 -> b (other lanes have a=0,b=0 -> 111111).
      run_beat("sel", 3'd7, 6'b000000, lv(1, 6'd1), lv(0, 6'b000111) | lv(1, 6'b000111),
               lv(0, 6'b111000) | lv(1, 6'b000111) | lv(2, 6'b111111) |
               lv(3, 6'b111111) | lv(4, 6'b111111) | lv(5, 6'b111111), 1'b0);
      check("no_ovf_after_logic_ops", ovf, 0);

      // Backpressure: five beats offered, two fit.
      out_ready = 1'b0; op = 3'd0; sgn = '0; b = '0; idx = 0;
      for (int c = 0; c < 5; c++) begin
         a = lv(0, 6'(idx + 1)); in_valid = 1'b1;
         #1;
         acc = in_ready;
         tick();
         if (acc) idx++;
      end
      check("bp_accepted", idx, 2);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_y", y, lv(0, 6'd1));
      tick();
      check("bp_y_hold", y, lv(0, 6'd1));

      out_ready = 1'b1; n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         in_valid = (idx < 5);
         a = lv(0, 6'(idx + 1));
         #1;
         if (out_valid && n < 5) begin
            got[n] = y[5:0];
            n++;
         end
         if (in_valid && in_ready) idx++;
         tick();
      end
      in_valid = 1'b0;
      check("bp_count", n, 5);
      for (int k = 0; k < 5; k++) check("bp_order", got[k], 6'(k + 1));

      // Flag clear racing an overflow beat: the new event wins, old flag clears.
      run_beat("add_ovf1", 3'd0, 6'b000000, lv(1, 6'd63), lv(1, 6'd1), 36'd0, 1'b0);
      check("ovf_lane1", ovf, 6'b000010);
      run_beat("sub_u", 3'd1, 6'b000000, lv(0, 6'd3), lv(0, 6'd5), lv(0, 6'b111110), 1'b1);
      check("clr_vs_set", ovf, 6'b000001);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check("clr_alone", ovf, 0);

      // Signed SUB 3-5=-2 no overflow.
      run_beat("sub_s", 3'd1, 6'b000001, lv(0, 6'd3), lv(0, 6'd5), lv(0, 6'b111110), 1'b0);
      check("sub_s_ovf", ovf, 0);

      // Reset with two beats in flight.
      out_ready = 1'b0; op = 3'd0; sgn = '0; b = '0;
      a = lv(0, 6'd7); in_valid = 1'b1;
      tick();
      a = lv(0, 6'd9);
      tick();
      in_valid = 1'b0;
      check("mid_full_valid", out_valid, 1);
      check("mid_full_y", y, lv(0, 6'd7));
      check("mid_full_in_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_y", y, 0);
      check("mid_rst_in_ready", in_ready, 1);
      #2 rst_n = 1'b1;
      out_ready = 1'b1; seen = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (out_valid) seen++;
      end
      check("post_rst_no_stale", seen, 0);
      check("post_rst_in_ready", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
